// File: rtl/fifos_to_axi4lite_master_pkg.sv
// fifos_to_axi4lite_master shared types and constants.
// FSM states, AXI response codes and field helpers.
package fifos_to_axi4lite_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_PUSH
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Command entry is {is_write, addr, wdata}; response is {is_write, resp, rdata}.
  localparam int CMD_EXTRA = 1;
  localparam int RSP_EXTRA = 3;

  function automatic logic resp_err(input logic [1:0] r);
    return r != RESP_OKAY;
  endfunction

endpackage

// File: rtl/fifos_to_axi4lite_master_fifo_pop_fetch.sv
// Command FIFO pop and read-latency alignment.
// Pops once, then presents the entry when it is valid.
module fifo_pop_fetch #(
  parameter int CMD_W      = 65,
  parameter int RD_LATENCY = 2
) (
  input  logic             clk_main_a0,
  input  logic             rst_main_sync,
  input  logic             start,
  output logic             fifo_cmd_rd,
  input  logic [CMD_W-1:0] fifo_cmd_dout,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd
);

  logic       active;
  logic [7:0] cnt;

  assign cmd_valid = active && (cnt == 8'd0);
  assign cmd       = fifo_cmd_dout;

  // Issue a one-cycle pop, then count down the FIFO read latency.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      fifo_cmd_rd <= 1'b0;
      active      <= 1'b0;
      cnt         <= 8'd0;
    end else begin
      fifo_cmd_rd <= 1'b0;
      if (start && !active) begin
        fifo_cmd_rd <= 1'b1;
        active      <= 1'b1;
        cnt         <= 8'(RD_LATENCY);
      end else if (active) begin
        if (cnt == 8'd0) active <= 1'b0;
        else cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: rtl/fifos_to_axi4lite_master.sv
// AXI4-Lite master fed by a command FIFO.
// One transaction in flight; results go to a response FIFO.
module fifos_to_axi4lite_master
  import fifos_to_axi4lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                               clk_main_a0,
  input  logic                               rst_main_sync,
  output logic                               fifo_cmd_rd,
  input  logic [CMD_EXTRA+ADDR_WIDTH+DATA_WIDTH-1:0] fifo_cmd_dout,
  input  logic                               fifo_cmd_empty,
  output logic                               fifo_rsp_wr,
  output logic [RSP_EXTRA+DATA_WIDTH-1:0]    fifo_rsp_din,
  input  logic                               fifo_rsp_full,
  output logic                               awvalid,
  output logic [ADDR_WIDTH-1:0]              awaddr,
  input  logic                               awready,
  output logic                               wvalid,
  output logic [DATA_WIDTH-1:0]              wdata,
  output logic [DATA_WIDTH/8-1:0]            wstrb,
  input  logic                               wready,
  input  logic                               bvalid,
  input  logic [1:0]                         bresp,
  output logic                               bready,
  output logic                               arvalid,
  output logic [ADDR_WIDTH-1:0]              araddr,
  input  logic                               arready,
  input  logic                               rvalid,
  input  logic [DATA_WIDTH-1:0]              rdata,
  input  logic [1:0]                         rresp,
  output logic                               rready,
  output logic                               busy,
  output logic [15:0]                        txn_count,
  output logic                               err_sticky
);

  localparam int CMD_W = CMD_EXTRA + ADDR_WIDTH + DATA_WIDTH;

  state_e                  state;
  logic                    start;
  logic                    cmd_valid;
  logic [CMD_W-1:0]        cmd;
  logic                    cmd_is_wr;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic                    rsp_is_wr;
  logic [1:0]              rsp_resp;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    aw_done;
  logic                    w_done;

  assign start     = (state == S_IDLE) && !fifo_cmd_empty && !fifo_rsp_full;
  assign busy      = (state != S_IDLE);
  assign cmd_is_wr = cmd[CMD_W-1];
  assign cmd_addr  = cmd[CMD_W-2 -: ADDR_WIDTH];
  assign cmd_data  = cmd[DATA_WIDTH-1:0];
  assign aw_done   = !awvalid || awready;
  assign w_done    = !wvalid || wready;

  fifo_pop_fetch #(
    .CMD_W      (CMD_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_fetch (
    .clk_main_a0   (clk_main_a0),
    .rst_main_sync (rst_main_sync),
    .start         (start),
    .fifo_cmd_rd   (fifo_cmd_rd),
    .fifo_cmd_dout (fifo_cmd_dout),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd)
  );

  // Transaction FSM with registered AXI and response-FIFO outputs.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      state        <= S_IDLE;
      awvalid      <= 1'b0;
      awaddr       <= '0;
      wvalid       <= 1'b0;
      wdata        <= '0;
      wstrb        <= '0;
      bready       <= 1'b0;
      arvalid      <= 1'b0;
      araddr       <= '0;
      rready       <= 1'b0;
      fifo_rsp_wr  <= 1'b0;
      fifo_rsp_din <= '0;
      rsp_is_wr    <= 1'b0;
      rsp_resp     <= 2'b00;
      rsp_data     <= '0;
      txn_count    <= 16'd0;
      err_sticky   <= 1'b0;
    end else begin
      fifo_rsp_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (cmd_valid) begin
            rsp_is_wr <= cmd_is_wr;
            if (cmd_is_wr) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_data;
              wstrb   <= '1;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR_REQ;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready   <= 1'b0;
            rsp_resp <= bresp;
            rsp_data <= '0;
            state    <= S_PUSH;
          end
        end
        S_RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (rvalid) begin
            rready   <= 1'b0;
            rsp_resp <= rresp;
            rsp_data <= rdata;
            state    <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (!fifo_rsp_full) begin
            fifo_rsp_wr  <= 1'b1;
            fifo_rsp_din <= {rsp_is_wr, rsp_resp, rsp_data};
            txn_count    <= txn_count + 16'd1;
            if (resp_err(rsp_resp)) err_sticky <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifos_to_axi4lite_master.sv
// Directed bench for fifos_to_axi4lite_master.
// Models the command FIFO and a scripted AXI slave.
module tb_fifos_to_axi4lite_master;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main_sync;
  logic        fifo_cmd_rd;
  logic [64:0] fifo_cmd_dout;
  logic        fifo_cmd_empty;
  logic        fifo_rsp_wr;
  logic [34:0] fifo_rsp_din;
  logic        fifo_rsp_full;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        busy;
  logic [15:0] txn_count;
  logic        err_sticky;

  int checks = 0;
  int failures = 0;

  logic [64:0] cmd_mem [0:15];
  int          q_wr = 0;
  int          q_rd = 0;
  int          cyc = 0;
  int          pops = 0;
  int          pop_cyc = 0;
  int          rsp_cyc = 0;
  int          rsp_n = 0;
  logic [34:0] rsp_mem [0:31];
  logic [31:0] aw_last = '0;
  logic [31:0] w_last = '0;
  logic [3:0]  wstrb_last = '0;
  logic [31:0] ar_last = '0;
  int          aw_cyc = 0;
  int          w_cyc = 0;
  int          aw_unstable = 0;
  logic        aw_prev_v = 1'b0;
  logic [31:0] aw_prev_a = '0;

  assign fifo_cmd_empty = (q_wr == q_rd);

  fifos_to_axi4lite_master dut (
    .clk_main_a0    (clk_main_a0),
    .rst_main_sync  (rst_main_sync),
    .fifo_cmd_rd    (fifo_cmd_rd),
    .fifo_cmd_dout  (fifo_cmd_dout),
    .fifo_cmd_empty (fifo_cmd_empty),
    .fifo_rsp_wr    (fifo_rsp_wr),
    .fifo_rsp_din   (fifo_rsp_din),
    .fifo_rsp_full  (fifo_rsp_full),
    .awvalid        (awvalid),
    .awaddr         (awaddr),
    .awready        (awready),
    .wvalid         (wvalid),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .wready         (wready),
    .bvalid         (bvalid),
    .bresp          (bresp),
    .bready         (bready),
    .arvalid        (arvalid),
    .araddr         (araddr),
    .arready        (arready),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .rresp          (rresp),
    .rready         (rready),
    .busy           (busy),
    .txn_count      (txn_count),
    .err_sticky     (err_sticky)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  // Command FIFO model and bus monitor.
  always @(posedge clk_main_a0) begin
    cyc <= cyc + 1;
    if (fifo_cmd_rd) begin
      fifo_cmd_dout <= cmd_mem[q_rd[3:0]];
      q_rd    <= q_rd + 1;
      pops    <= pops + 1;
      pop_cyc <= cyc;
    end
    if (fifo_rsp_wr) begin
      rsp_mem[rsp_n[4:0]] <= fifo_rsp_din;
      rsp_n   <= rsp_n + 1;
      rsp_cyc <= cyc;
    end
    if (awvalid) aw_cyc <= aw_cyc + 1;
    if (wvalid) w_cyc <= w_cyc + 1;
    if (awvalid && aw_prev_v && awaddr != aw_prev_a)
      aw_unstable <= aw_unstable + 1;
    aw_prev_v <= awvalid;
    aw_prev_a <= awaddr;
    if (awvalid && awready) aw_last <= awaddr;
    if (wvalid && wready) begin
      w_last     <= wdata;
      wstrb_last <= wstrb;
    end
    if (arvalid && arready) ar_last <= araddr;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic is_wr, input logic [31:0] a,
                          input logic [31:0] d);
    cmd_mem[q_wr[3:0]] = {is_wr, a, d};
    q_wr = q_wr + 1;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 200 && rsp_n < target; i++)
      @(negedge clk_main_a0);
    chk("rsp_done", 64'(rsp_n), 64'(target));
  endtask

  task automatic do_reset();
    @(negedge clk_main_a0);
    rst_main_sync = 1'b1;
    repeat (2) @(negedge clk_main_a0);
    rst_main_sync = 1'b0;
    @(negedge clk_main_a0);
  endtask

  int rn;
  int pn;
  int a0;
  int w0;
  int u0;

  initial begin
    rst_main_sync = 1'b1;
    fifo_cmd_dout = '0;
    fifo_rsp_full = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b1;
    bresp   = 2'b00;
    arready = 1'b1;
    rvalid  = 1'b1;
    rresp   = 2'b00;
    rdata   = '0;
    do_reset();

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_txn", 64'(txn_count), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    chk("rst_strobes",
        64'({fifo_cmd_rd, fifo_rsp_wr, awvalid, wvalid, bready,
             arvalid, rready}), 64'd0);
    chk("rst_rsp_din", 64'(fifo_rsp_din), 64'd0);

    push_cmd(1'b1, 32'h10, 32'hDEADBEEF);
    wait_rsp(1);
    chk("wr_rsp", 64'(rsp_mem[0]), 64'({1'b1, 2'b00, 32'h0}));
    chk("wr_awaddr", 64'(aw_last), 64'h10);
    chk("wr_wdata", 64'(w_last), 64'hDEADBEEF);
    chk("wr_wstrb", 64'(wstrb_last), 64'hF);
    chk("wr_latency", 64'(rsp_cyc - pop_cyc), 64'd6);
    chk("wr_txn", 64'(txn_count), 64'd1);
    chk("wr_err", 64'(err_sticky), 64'd0);

    rdata = 32'h12345678;
    rresp = 2'b10;
    push_cmd(1'b0, 32'h20, 32'h0);
    wait_rsp(2);
    chk("rd_rsp", 64'(rsp_mem[1]), 64'({1'b0, 2'b10, 32'h12345678}));
    chk("rd_araddr", 64'(ar_last), 64'h20);
    chk("rd_latency", 64'(rsp_cyc - pop_cyc), 64'd6);
    chk("rd_err", 64'(err_sticky), 64'd1);
    rresp = 2'b00;
    push_cmd(1'b1, 32'h30, 32'h1);
    wait_rsp(3);
    chk("err_hold", 64'(err_sticky), 64'd1);
    chk("txn3", 64'(txn_count), 64'd3);

    awready = 1'b0;
    rn = rsp_n;
    a0 = aw_cyc;
    w0 = w_cyc;
    u0 = aw_unstable;
    push_cmd(1'b1, 32'h44, 32'hCAFEF00D);
    for (int i = 0; i < 50 && !awvalid; i++) @(negedge clk_main_a0);
    chk("aw_seen", 64'(awvalid), 64'd1);
    repeat (3) @(negedge clk_main_a0);
    awready = 1'b1;
    wait_rsp(rn + 1);
    repeat (10) @(negedge clk_main_a0);
    chk("aw_cycles", 64'(aw_cyc - a0), 64'd4);
    chk("w_cycles", 64'(w_cyc - w0), 64'd1);
    chk("aw_stable", 64'(aw_unstable - u0), 64'd0);
    chk("aw_addr", 64'(aw_last), 64'h44);
    chk("one_push", 64'(rsp_n), 64'(rn + 1));
    chk("slow_rsp", 64'(rsp_mem[rn]), 64'({1'b1, 2'b00, 32'h0}));

    do_reset();
    chk("rst2_txn", 64'(txn_count), 64'd0);
    chk("rst2_err", 64'(err_sticky), 64'd0);
    fifo_rsp_full = 1'b1;
    rdata = 32'hA5A50F0F;
    rn = rsp_n;
    pn = pops;
    push_cmd(1'b1, 32'h50, 32'h55);
    push_cmd(1'b0, 32'h60, 32'h0);
    repeat (20) @(negedge clk_main_a0);
    chk("full_no_pop", 64'(pops - pn), 64'd0);
    chk("full_idle", 64'(busy), 64'd0);
    fifo_rsp_full = 1'b0;
    wait_rsp(rn + 2);
    chk("order0", 64'(rsp_mem[rn]), 64'({1'b1, 2'b00, 32'h0}));
    chk("order1", 64'(rsp_mem[rn + 1]), 64'({1'b0, 2'b00, 32'hA5A50F0F}));
    chk("full_txn", 64'(txn_count), 64'd2);
    chk("full_aw", 64'(aw_last), 64'h50);
    chk("full_ar", 64'(ar_last), 64'h60);

    rvalid = 1'b0;
    push_cmd(1'b0, 32'h70, 32'h0);
    for (int i = 0; i < 50 && !rready; i++) @(negedge clk_main_a0);
    chk("rready_up", 64'(rready), 64'd1);
    rn = rsp_n;
    rst_main_sync = 1'b1;
    @(negedge clk_main_a0);
    chk("abort_rready", 64'(rready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    rst_main_sync = 1'b0;
    repeat (5) @(negedge clk_main_a0);
    chk("abort_no_push", 64'(rsp_n), 64'(rn));
    rvalid = 1'b1;
    rdata = 32'h0BADF00D;
    push_cmd(1'b0, 32'h74, 32'h0);
    wait_rsp(rn + 1);
    chk("after_abort", 64'(rsp_mem[rn]), 64'({1'b0, 2'b00, 32'h0BADF00D}));
    chk("after_abort_ar", 64'(ar_last), 64'h74);
    chk("after_abort_txn", 64'(txn_count), 64'd1);

    @(negedge clk_main_a0);
    force dut.txn_count = 16'hFFFF;
    @(negedge clk_main_a0);
    release dut.txn_count;
    @(negedge clk_main_a0);
    chk("preset", 64'(txn_count), 64'hFFFF);
    rn = rsp_n;
    push_cmd(1'b1, 32'h80, 32'h8);
    wait_rsp(rn + 1);
    chk("wrap", 64'(txn_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
